// File: rtl/stream_mux_n_pkg.sv
// Shared constants and helpers for the stream_mux_n multiplexer and its round-robin picker.
package stream_mux_n_pkg;

  localparam int DEF_NUM_IN = 4;
  localparam int DEF_DATA_W = 8;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Index width for n items; never below 1 so a port always has a bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/stream_mux_n_rr_pick.sv
// Combinational round-robin picker: rotate valids by ptr, take the lowest set bit, rotate back.
module stream_mux_n_rr_pick
  import stream_mux_n_pkg::*;
#(
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int SEL_W  = clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] valid,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  chosen,
  output logic              any_valid
);

  logic [NUM_IN-1:0] rot;
  int                idx;
  int                off;
  int                sum;

  always_comb begin
    rot = '0;
    idx = 0;
    off = 0;
    sum = 0;
    for (int j = 0; j < NUM_IN; j++) begin
      idx = int'(ptr) + j;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      rot[j] = valid[SEL_W'(idx)];
    end
    for (int j = NUM_IN - 1; j >= 0; j--) begin
      if (rot[j]) off = j;
    end
    any_valid = |rot;
    sum = int'(ptr) + off;
    if (sum >= NUM_IN) sum = sum - NUM_IN;
    chosen = SEL_W'(sum);
  end

endmodule

// File: rtl/stream_mux_n.sv
// N-input valid/ready stream multiplexer with explicit-select or round-robin choice and a registered output beat.
module stream_mux_n
  import stream_mux_n_pkg::*;
#(
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEL_W  = clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_src,
  output logic                     out_valid,
  input  logic                     out_ready
);

  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  rr_chosen;
  logic              rr_any;
  logic [SEL_W-1:0]  chosen_p0;
  logic              grant_ok;
  logic              load_en;
  logic              xfer_p0;
  logic [DATA_W-1:0] data_p0;
  logic [DATA_W-1:0] data_p1;
  logic [SEL_W-1:0]  src_p1;
  logic              vld_p1;

  stream_mux_n_rr_pick #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_rr_pick (
    .valid     (in_valid),
    .ptr       (ptr),
    .chosen    (rr_chosen),
    .any_valid (rr_any)
  );

  assign load_en = !vld_p1 || out_ready;

  // Stage p0: choose a channel and form the handshake
  always_comb begin
    if (mode == MODE_RR) begin
      chosen_p0 = rr_chosen;
      grant_ok  = rr_any;
    end else begin
      chosen_p0 = sel;
      grant_ok  = (int'(sel) < NUM_IN);
    end
    in_ready = '0;
    data_p0  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready[i] = load_en && grant_ok && (SEL_W'(i) == chosen_p0);
      if (SEL_W'(i) == chosen_p0) data_p0 = in_data[i*DATA_W +: DATA_W];
    end
    xfer_p0 = |(in_valid & in_ready);
  end

  // Stage p1: the single output beat and the round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      src_p1  <= '0;
      ptr     <= '0;
    end else begin
      if (load_en) begin
        vld_p1 <= xfer_p0;
        if (xfer_p0) begin
          data_p1 <= data_p0;
          src_p1  <= chosen_p0;
        end
      end
      if (xfer_p0 && mode == MODE_RR) begin
        ptr <= (chosen_p0 == SEL_W'(NUM_IN - 1)) ? '0 : chosen_p0 + 1'b1;
      end
    end
  end

  assign out_data  = data_p1;
  assign out_src   = src_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_stream_mux_n.sv
// Self-checking bench for stream_mux_n: directed scenarios plus randomized traffic against a reference model.
module tb_stream_mux_n;

  localparam int N = 4;
  localparam int W = 8;
  localparam int S = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             mode;
  logic [S-1:0]     sel;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic [W-1:0]     out_data;
  logic [S-1:0]     out_src;
  logic             out_valid;
  logic             out_ready;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit             m_vld;
  logic [W-1:0]   m_data;
  int             m_src;
  int             m_ptr;

  stream_mux_n #(.NUM_IN(N), .DATA_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic md, input logic [S-1:0] s, input logic [N-1:0] v, input logic ordy);
    mode      = md;
    sel       = s;
    in_valid  = v;
    out_ready = ordy;
    #1;
  endtask

  task automatic model_reset();
    m_vld  = 0;
    m_data = '0;
    m_src  = 0;
    m_ptr  = 0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = '0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    model_reset();
    #1;
  endtask

  // Expected handshake for the current inputs, derived from the selection rules.
  task automatic model_eval(output logic [N-1:0] rdy, output bit xf, output int ch);
    bit load;
    bit ok;
    int c;
    ok   = 0;
    ch   = 0;
    rdy  = '0;
    xf   = 0;
    load = !m_vld || out_ready;
    if (mode == 1'b0) begin
      ch = int'(sel);
      ok = (ch < N);
    end else begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (!ok && in_valid[c]) begin
          ch = c;
          ok = 1;
        end
      end
    end
    if (load && ok) begin
      rdy[ch] = 1'b1;
      xf = in_valid[ch];
    end
  endtask

  task automatic model_commit(input bit xf, input int ch);
    if (!m_vld || out_ready) begin
      m_vld = xf;
      if (xf) begin
        m_data = in_data[ch*W +: W];
        m_src  = ch;
        if (mode == 1'b1) m_ptr = (ch + 1) % N;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    checks++;
    if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", out_data); end
    checks++;
    if (out_src !== 2'd0) begin errors++; $display("FAIL reset_src got %0d want 0", out_src); end
  endtask

  task automatic test_select();
    in_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    drive(1'b0, 2'd2, 4'b1111, 1'b1);
    checks++;
    if (in_ready !== 4'b0100) begin errors++; $display("FAIL sel_ready got %b want 0100", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_src !== 2'd2) begin
      errors++; $display("FAIL sel_out got v=%0b d=%h s=%0d want v=1 d=a5 s=2", out_valid, out_data, out_src);
    end
  endtask

  task automatic test_backpressure();
    in_data[2*W +: W] = 8'h3C;
    drive(1'b0, 2'd2, 4'b1111, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got %b want 0000", i, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%0b d=%h want v=1 d=a5", i, out_valid, out_data);
      end
    end
    drive(1'b0, 2'd2, 4'b1111, 1'b1);
    checks++;
    if (in_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready got %b want 0100", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h3C || out_src !== 2'd2) begin
      errors++; $display("FAIL bp_release got v=%0b d=%h s=%0d want v=1 d=3c s=2", out_valid, out_data, out_src);
    end
  endtask

  task automatic test_rr_all();
    int exp;
    do_reset();
    in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    drive(1'b1, 2'd0, 4'b1111, 1'b1);
    for (int i = 0; i < 5; i++) begin
      exp = i % N;
      checks++;
      if (in_ready !== 4'(1 << exp)) begin errors++; $display("FAIL rr_all_ready[%0d] got %b want ch%0d", i, in_ready, exp); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_src !== 2'(exp) || out_data !== 8'(8'h10 + exp)) begin
        errors++; $display("FAIL rr_all_out[%0d] got v=%0b s=%0d d=%h want v=1 s=%0d d=%h",
                           i, out_valid, out_src, out_data, exp, 8'h10 + exp);
      end
    end
  endtask

  task automatic test_rr_sparse();
    int exp_seq [3] = '{3, 1, 3};
    // pointer sits at 1 after the previous scenario; one ch1 grant moves it to 2
    drive(1'b1, 2'd0, 4'b0010, 1'b1);
    tick();
    checks++;
    if (out_src !== 2'd1) begin errors++; $display("FAIL rr_sparse_setup got s=%0d want 1", out_src); end
    drive(1'b1, 2'd0, 4'b1010, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_src !== 2'(exp_seq[i]) || out_data !== 8'(8'h10 + exp_seq[i])) begin
        errors++; $display("FAIL rr_sparse[%0d] got v=%0b s=%0d d=%h want s=%0d", i, out_valid, out_src, out_data, exp_seq[i]);
      end
    end
  endtask

  task automatic test_select_invalid();
    drive(1'b0, 2'd2, 4'b1011, 1'b1);
    checks++;
    if (in_ready !== 4'b0100) begin errors++; $display("FAIL selinv_ready got %b want 0100", in_ready); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h13 || out_src !== 2'd3) begin
        errors++; $display("FAIL selinv_out[%0d] got v=%0b d=%h s=%0d want v=0 d=13 s=3", i, out_valid, out_data, out_src);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 2'd0, 4'b1111, 1'b0);
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre got v=%0b want 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 2'd0) begin
      errors++; $display("FAIL rstmid_async got v=%0b d=%h s=%0d want 0/00/0", out_valid, out_data, out_src);
    end
    tick();
    rst_n = 1'b1;
    model_reset();
    drive(1'b1, 2'd0, 4'b1111, 1'b1);
    checks++;
    if (in_ready !== 4'b0001) begin errors++; $display("FAIL rstmid_ptr got %b want 0001", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 8'h10) begin
      errors++; $display("FAIL rstmid_first got v=%0b s=%0d d=%h want 1/0/10", out_valid, out_src, out_data);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] er;
    bit           xf;
    int           ch;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      mode      = ($urandom_range(0, 3) != 0);
      sel       = S'($urandom_range(0, N - 1));
      in_valid  = N'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      model_eval(er, xf, ch);
      checks++;
      if (in_ready !== er) begin errors++; $display("FAIL rand_ready[%0d] got %b want %b", cyc, in_ready, er); end
      model_commit(xf, ch);
      tick();
      checks++;
      if (out_valid !== m_vld || out_data !== m_data || out_src !== S'(m_src)) begin
        errors++; $display("FAIL rand_out[%0d] got v=%0b d=%h s=%0d want v=%0b d=%h s=%0d",
                           cyc, out_valid, out_data, out_src, m_vld, m_data, m_src);
      end
    end
  endtask

  initial begin
    test_reset();
    test_select();
    test_backpressure();
    test_rr_all();
    test_rr_sparse();
    test_select_invalid();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_mux_n.md
Name: stream_mux_n

Overview:
- Parametrised successor of the fixed 4:1 bit multiplexer: NUM_IN-input, DATA_W-bit stream multiplexer with valid/ready handshakes on every input and on the output.
- Two modes: explicit select, or round-robin arbitration across valid inputs.
- Output is registered (one beat of storage), so the block is a pipeline stage in larger benchmark datapaths.

Parameters:
- NUM_IN, 4, number of input channels (>= 2).
- DATA_W, 8, data width per channel.
- SEL_W, clog2(NUM_IN), select/source index width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mode  in  1  0 = select mode, 1 = round-robin mode.
- sel  in  SEL_W  channel index used in select mode.
- in_data  in  NUM_IN*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  in  NUM_IN  per-channel valid.
- in_ready  out  NUM_IN  per-channel ready (combinational).
- out_data  out  DATA_W  registered output data.
- out_src  out  SEL_W  index of the channel that supplied out_data.
- out_valid  out  1  registered output valid.
- out_ready  in  1  downstream ready.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_src=0, rr pointer ptr=0.
- load_en = !out_valid || out_ready. One output register, with full throughput (1 beat/cycle) when out_ready is held high.
- Select mode: chosen = sel.
  - If sel >= NUM_IN, no channel is chosen: all in_ready=0 and there is no load.
  - Otherwise in_ready[i] = load_en && (i==sel). in_valid of unselected channels is ignored.
- Round-robin mode: chosen = first i with in_valid[i]=1, scanning ptr, ptr+1, ... wrapping modulo NUM_IN.
  - in_ready[i] = load_en && any_valid && (i==chosen).
  - On a transfer, ptr <= (chosen+1) mod NUM_IN, wrapping from NUM_IN-1 to 0.
  - ptr is unchanged when there is no transfer.
- Transfer: occurs when in_valid[chosen] && in_ready[chosen]. At the next edge:
  - out_data <= that channel's data;
  - out_src <= chosen;
  - out_valid <= 1.
- Latency is 1 cycle from input handshake to out_valid.
- If load_en && no transfer: out_valid <= 0 at the next edge. out_data and out_src hold their last values.
- If out_valid && !out_ready: out_data, out_src and out_valid hold, and all in_ready=0.
- Simultaneous drain and refill (out_valid && out_ready && new transfer): the new beat replaces the old one, with no bubble.
- mode or sel changes take effect on the current cycle's combinational choice only. They never alter a held output beat. ptr is retained across mode switches.
- Reset mid-operation: the held beat is discarded, out_valid drops immediately, and ptr returns to 0.
- No data path in_data -> out_data is combinational. Only in_ready depends combinationally on in_valid, out_ready, mode and sel.

Decomposition:
- Shared package holds:
  - clog2 function;
  - mode encodings MODE_SEL=0 and MODE_RR=1;
  - default width constants.
- One sub-module: rr_pick. It is combinational and returns chosen index and any_valid from the in_valid vector and ptr, using a rotate, then priority-encode, then un-rotate.
- The top level owns the register stage, ptr and the handshake logic.

Test Plan (NUM_IN=4, DATA_W=8):
1. Select mode, sel=2, in_data ch2=0xA5, all valid, out_ready=1 -> in_ready=4'b0100; next cycle out_data=0xA5, out_src=2, out_valid=1.
2. Backpressure: out_valid=1, out_ready=0 for 3 cycles with new ch2 data 0x3C -> in_ready=0; out_data holds 0xA5. Raise out_ready -> 0x3C appears one cycle later.
3. Round-robin, all four valid, out_ready=1, ch i data=0x10+i -> out_src sequence 0,1,2,3,0 with data 0x10,0x11,0x12,0x13,0x10, back-to-back with no bubbles.
4. Round-robin, only ch1 and ch3 valid, ptr=2 -> grant ch3 first, then ch1 (wrap), then ch3.
5. Select mode, sel=2 while in_valid[2]=0 but others valid -> no transfer; out_valid falls to 0 after the previous beat drains.
6. Assert rst_n=0 mid-stream while out_valid=1 -> out_valid=0, out_data=0, out_src=0 immediately. After release, round-robin grants start from ch0.
